pll_lock_sequencer: RTL and testbench



---
 rtl/clk_rst_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 107 ++++++++++
 tb/tb_pll_lock_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared clock/reset sequencing types: PLL lock FSM states, output bundle and helpers.
package clk_rst_pkg;

    localparam int unsigned RETRY_W = 8;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } lock_state_e;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
    } seq_outs_t;

    // Level outputs owned by each state; loaded on the edge that enters it.
    function automatic seq_outs_t state_outs(input lock_state_e s);
        seq_outs_t o;
        o.pll_rst = (s == PLL_RESET);
        o.sys_rst = (s != RUN);
        o.ready   = (s == RUN);
        return o;
    endfunction

    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer, async active-high reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL RST, qualifies LOCK, releases sys_rst, retries on failure.
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked_async,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    import clk_rst_pkg::*;

    localparam int unsigned CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic                locked_s;
    lock_state_e         state;
    logic [CNT_W-1:0]    cnt;
    seq_outs_t           outs_q;
    logic [RETRY_W-1:0]  retry_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked_async),
        .q   (locked_s)
    );

    // Lock is tested before timeout so a lock arriving on the last wait cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PLL_RESET;
            cnt       <= '0;
            outs_q    <= state_outs(PLL_RESET);
            lock_lost <= 1'b0;
            retry_q   <= '0;
        end else begin
            lock_lost <= 1'b0;
            unique case (state)
                PLL_RESET: begin
                    if (cnt == RST_LAST) begin
                        state  <= WAIT_LOCK;
                        cnt    <= '0;
                        outs_q <= state_outs(WAIT_LOCK);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state  <= STABLE;
                        cnt    <= '0;
                        outs_q <= state_outs(STABLE);
                    end else if (cnt == TIMEOUT_LAST) begin
                        state   <= PLL_RESET;
                        cnt     <= '0;
                        outs_q  <= state_outs(PLL_RESET);
                        retry_q <= retry_inc(retry_q);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state  <= WAIT_LOCK;
                        cnt    <= '0;
                        outs_q <= state_outs(WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state  <= RUN;
                        cnt    <= '0;
                        outs_q <= state_outs(RUN);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state     <= PLL_RESET;
                        cnt       <= '0;
                        outs_q    <= state_outs(PLL_RESET);
                        lock_lost <= 1'b1;
                        retry_q   <= retry_inc(retry_q);
                    end
                end
            endcase
        end
    end

    assign pll_rst     = outs_q.pll_rst;
    assign sys_rst     = outs_q.sys_rst;
    assign ready       = outs_q.ready;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected output snapshots queued per clock edge.
module tb_pll_lock_sequencer;

    localparam int unsigned RP  = 4;
    localparam int unsigned LS  = 8;
    localparam int unsigned LT  = 32;
    localparam int          PER = RP + LT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked_async = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int base     = 0;
    int ll_cnt   = 0;
    int ll_mark  = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (LT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pll_locked_async (pll_locked_async),
        .pll_rst          (pll_rst),
        .sys_rst          (sys_rst),
        .ready            (ready),
        .lock_lost        (lock_lost),
        .retry_count      (retry_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (pll_rst,sys_rst,ready,lock_lost,retry)",
                     tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ov(input logic p, input logic s, input logic r,
                                       input logic l, input int rc);
        return {p, s, r, l, 8'(rc)};
    endfunction

    function automatic logic [11:0] obs();
        return {pll_rst, sys_rst, ready, lock_lost, retry_count};
    endfunction

    // Edge e is the e-th rising edge after rst is released.
    task automatic expect_at(input int e, input string tag, input logic [11:0] v);
        exp_t x;
        x.cyc = base + e;
        x.tag = $sformatf("%s@e%0d", tag, e);
        x.exp = v;
        sb.push_back(x);
    endtask

    task automatic wait_edge(input int e);
        while (cyc < base + e) @(negedge clk);
    endtask

    task automatic reset_dut(input logic lock);
        @(negedge clk);
        rst = 1'b1;
        pll_locked_async = lock;
        repeat (2) @(negedge clk);
        check("reset_state", obs(), ov(1, 1, 0, 0, 0));
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(tag, 12'(sb.size()), 12'd0);
        sb.delete();
    endtask

    // Compare queued expectations on the falling edge after their rising edge.
    always @(negedge clk) begin
        exp_t h;
        if (lock_lost) ll_cnt++;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            h = sb.pop_front();
            check(h.tag, obs(), h.exp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Locked from the start: 4-cycle PLL reset, STABLE at edge 5, RUN at edge 13.
        reset_dut(1'b1);
        ll_cnt = 0;
        expect_at(1,  "s1_prst", ov(1, 1, 0, 0, 0));
        expect_at(3,  "s1_prst", ov(1, 1, 0, 0, 0));
        expect_at(4,  "s1_wait", ov(0, 1, 0, 0, 0));
        expect_at(12, "s1_stab", ov(0, 1, 0, 0, 0));
        expect_at(13, "s1_run",  ov(0, 0, 1, 0, 0));
        expect_at(20, "s1_run",  ov(0, 0, 1, 0, 0));
        wait_edge(21);
        check("s1_no_lock_lost", 12'(ll_cnt), 12'd0);
        drain("s1_drain");

        // Never locked: timeout k lands on edge 36k; then lock arrives and STABLE is reached.
        reset_dut(1'b0);
        for (int k = 1; k <= 3; k++) begin
            expect_at(PER * k - 1, "s2_wait",  ov(0, 1, 0, 0, k - 1));
            expect_at(PER * k,     "s2_retry", ov(1, 1, 0, 0, k));
            expect_at(PER * k + 3, "s2_prst",  ov(1, 1, 0, 0, k));
            expect_at(PER * k + 4, "s2_wait",  ov(0, 1, 0, 0, k));
        end
        expect_at(113, "s5_stab", ov(0, 1, 0, 0, 3));
        expect_at(115, "s5_stab", ov(0, 1, 0, 0, 3));
        wait_edge(108);
        pll_locked_async = 1'b1;
        wait_edge(115);
        drain("s2_drain");
        // Async reset between edges while in STABLE.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("s5_async_rst", obs(), ov(1, 1, 0, 0, 0));

        // Glitch during STABLE at cnt=5, then lock loss in RUN and relock.
        reset_dut(1'b1);
        ll_cnt = 0;
        expect_at(4,  "s3_wait",   ov(0, 1, 0, 0, 0));
        expect_at(10, "s3_stab",   ov(0, 1, 0, 0, 0));
        expect_at(11, "s3_rewait", ov(0, 1, 0, 0, 0));
        expect_at(12, "s3_stab",   ov(0, 1, 0, 0, 0));
        expect_at(13, "s3_noready", ov(0, 1, 0, 0, 0));
        expect_at(19, "s3_stab",   ov(0, 1, 0, 0, 0));
        expect_at(20, "s3_run",    ov(0, 0, 1, 0, 0));
        expect_at(24, "s4_run",    ov(0, 0, 1, 0, 0));
        expect_at(25, "s4_lost",   ov(1, 1, 0, 1, 1));
        expect_at(26, "s4_prst",   ov(1, 1, 0, 0, 1));
        expect_at(28, "s4_prst",   ov(1, 1, 0, 0, 1));
        expect_at(29, "s4_wait",   ov(0, 1, 0, 0, 1));
        expect_at(30, "s4_stab",   ov(0, 1, 0, 0, 1));
        expect_at(37, "s4_stab",   ov(0, 1, 0, 0, 1));
        expect_at(38, "s4_run",    ov(0, 0, 1, 0, 1));
        wait_edge(8);
        pll_locked_async = 1'b0;
        wait_edge(9);
        pll_locked_async = 1'b1;
        wait_edge(22);
        pll_locked_async = 1'b0;
        ll_mark = ll_cnt;
        wait_edge(26);
        pll_locked_async = 1'b1;
        wait_edge(39);
        check("s4_one_pulse", 12'(ll_cnt - ll_mark), 12'd1);
        drain("s34_drain");

        // 300 timeouts: retry_count saturates at 255 while retries continue.
        reset_dut(1'b0);
        expect_at(PER * 254,     "s6_254",   ov(1, 1, 0, 0, 254));
        expect_at(PER * 255,     "s6_255",   ov(1, 1, 0, 0, 255));
        expect_at(PER * 256 - 1, "s6_wait",  ov(0, 1, 0, 0, 255));
        expect_at(PER * 256,     "s6_sat",   ov(1, 1, 0, 0, 255));
        expect_at(PER * 300,     "s6_sat",   ov(1, 1, 0, 0, 255));
        expect_at(PER * 300 + 4, "s6_wait",  ov(0, 1, 0, 0, 255));
        wait_edge(PER * 300 + 5);
        drain("s6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
